// File: rtl/ext_pipe_if.sv
// ext_pipe_if: handshake bundle between the decode stage and the immediate extender.
//   in_valid  / in_ready   input transfer handshake
//   imm, EOp               immediate and extension mode (sampled on accept)
//   out_valid / out_ready  output transfer handshake
//   ext, out_err           extended result and illegal-mode flag
// Modports: slave = extender side, master = producer/consumer side.
interface ext_pipe_if #(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32
) ();
  logic              in_valid;
  logic              in_ready;
  logic [IMM_W-1:0]  imm;
  logic [2:0]        EOp;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] ext;
  logic              out_err;

  modport slave (
    input  in_valid, imm, EOp, out_ready,
    output in_ready, out_valid, ext, out_err
  );

  modport master (
    output in_valid, imm, EOp, out_ready,
    input  in_ready, out_valid, ext, out_err
  );
endinterface

// File: rtl/ext_pipe.sv
// ext_pipe: registered immediate extender with a 2-entry (main + skid) output buffer.
// Widens an IMM_W-bit immediate to DATA_W bits in one of five modes; modes
// 101-111 are illegal and produce ext=0 with out_err=1.
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   bus         ext_pipe_if.slave (in_valid/in_ready/imm/EOp, out_valid/out_ready/ext/out_err)
//   clr_err     synchronous clear of err_sticky
//   err_sticky  set by any accepted illegal EOp, held until cleared (set wins)
module ext_pipe #(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32,
  parameter int SHIFT  = 2
) (
  input  logic       clk,
  input  logic       reset,
  ext_pipe_if.slave  bus,
  input  logic       clr_err,
  output logic       err_sticky
);

  if (DATA_W < IMM_W + SHIFT) begin : g_bad_params
    $error("ext_pipe: DATA_W must be >= IMM_W + SHIFT");
  end

  // Returns {illegal, result}.
  function automatic logic [DATA_W:0] extend(input logic [IMM_W-1:0] v,
                                             input logic [2:0]       mode);
    logic signed [IMM_W-1:0]  sv;
    logic signed [DATA_W-1:0] sx;
    logic        [DATA_W-1:0] zx;
    logic        [DATA_W-1:0] r;
    logic                     bad;
    sv  = signed'(v);
    sx  = DATA_W'(sv);
    zx  = DATA_W'(v);
    r   = '0;
    bad = 1'b0;
    case (mode)
      3'b000:  r = sx;
      3'b001:  r = zx;
      3'b010:  r = zx << (DATA_W - IMM_W);
      3'b011:  r = sx << SHIFT;
      3'b100:  r = zx << SHIFT;
      default: begin
        r   = '0;
        bad = 1'b1;
      end
    endcase
    return {bad, r};
  endfunction

  // ---- stage p0: combinational extension at the input ----
  logic [DATA_W:0] res_p0;
  logic            acc_p0;
  logic            drain_p0;

  // ---- stage p1: main (M) and skid (S) registers ----
  logic              vld_p1;
  logic [DATA_W-1:0] m_ext_p1;
  logic              m_err_p1;
  logic              s_vld_p1;
  logic [DATA_W-1:0] s_ext_p1;
  logic              s_err_p1;
  logic              rdy_p1;

  logic vld_n;
  logic s_vld_n;
  logic ld_m_new;
  logic ld_m_skid;
  logic ld_s;

  assign res_p0   = extend(bus.imm, bus.EOp);
  assign acc_p0   = bus.in_valid & rdy_p1;
  assign drain_p0 = vld_p1 & bus.out_ready;

  // rdy_p1 mirrors !s_vld_p1, so an accept never coincides with a full skid
  // register and the M<=S refill path never has to merge a new item.
  always_comb begin
    vld_n     = vld_p1;
    s_vld_n   = s_vld_p1;
    ld_m_new  = 1'b0;
    ld_m_skid = 1'b0;
    ld_s      = 1'b0;
    if (!vld_p1 || drain_p0) begin
      if (s_vld_p1) begin
        ld_m_skid = 1'b1;
        s_vld_n   = 1'b0;
        vld_n     = 1'b1;
      end else if (acc_p0) begin
        ld_m_new = 1'b1;
        vld_n    = 1'b1;
      end else begin
        vld_n = 1'b0;
      end
    end else if (acc_p0) begin
      ld_s    = 1'b1;
      s_vld_n = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1     <= 1'b0;
      s_vld_p1   <= 1'b0;
      rdy_p1     <= 1'b0;
      err_sticky <= 1'b0;
      m_ext_p1   <= '0;
      m_err_p1   <= 1'b0;
    end else begin
      vld_p1   <= vld_n;
      s_vld_p1 <= s_vld_n;
      rdy_p1   <= !s_vld_n;
      if (acc_p0 && res_p0[DATA_W]) begin
        err_sticky <= 1'b1;
      end else if (clr_err) begin
        err_sticky <= 1'b0;
      end
      if (ld_m_new) begin
        {m_err_p1, m_ext_p1} <= res_p0;
      end else if (ld_m_skid) begin
        {m_err_p1, m_ext_p1} <= {s_err_p1, s_ext_p1};
      end
    end
  end

  // Skid payload is only observed through M after s_vld_p1, so it needs no reset.
  always_ff @(posedge clk) begin
    if (ld_s) begin
      {s_err_p1, s_ext_p1} <= res_p0;
    end
  end

  assign bus.in_ready  = rdy_p1;
  assign bus.out_valid = vld_p1;
  assign bus.ext       = m_ext_p1;
  assign bus.out_err   = m_err_p1;

endmodule

// File: tb/tb_ext_pipe.sv
module tb_ext_pipe;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clr_err = 1'b0;
  logic err_sticky;

  int errors = 0;
  int checks = 0;
  int push_cnt = 0;
  int pop_cnt = 0;
  int sent = 0;

  logic [32:0] sb[$];
  logic [32:0] e;
  logic [31:0] t2_exp [5];

  ext_pipe_if #(.IMM_W(16), .DATA_W(32)) bif ();

  ext_pipe #(.IMM_W(16), .DATA_W(32), .SHIFT(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bif),
    .clr_err    (clr_err),
    .err_sticky (err_sticky)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [32:0] model(input logic [15:0] v, input logic [2:0] m);
    case (m)
      3'd0:    return {1'b0, {16{v[15]}}, v};
      3'd1:    return {1'b0, 16'h0000, v};
      3'd2:    return {1'b0, v, 16'h0000};
      3'd3:    return {1'b0, ({{16{v[15]}}, v} << 2)};
      3'd4:    return {1'b0, ({16'h0000, v} << 2)};
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: push on accept, pop/compare on drain (sampled on the falling edge).
  always @(negedge clk) begin
    if (reset) begin
      if (bif.out_valid && bif.out_ready) begin
        pop_cnt++;
        check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("sb_item", {31'd0, bif.out_err, bif.ext}, {31'd0, e});
        end
      end
      if (bif.in_valid && bif.in_ready) begin
        sb.push_back(model(bif.imm, bif.EOp));
        push_cnt++;
      end
    end
  end

  initial begin
    t2_exp[0] = 32'hFFFF8004;
    t2_exp[1] = 32'h00008004;
    t2_exp[2] = 32'h80040000;
    t2_exp[3] = 32'hFFFE0010;
    t2_exp[4] = 32'h00020010;
    bif.in_valid  = 1'b0;
    bif.imm       = '0;
    bif.EOp       = '0;
    bif.out_ready = 1'b0;

    // T1: reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("t1_out_valid", bif.out_valid, 0);
    check("t1_ext", bif.ext, 0);
    check("t1_out_err", bif.out_err, 0);
    check("t1_sticky", err_sticky, 0);
    check("t1_in_ready", bif.in_ready, 0);
    tick();
    reset = 1'b1;
    #1;
    check("t1_in_ready_pre_edge", bif.in_ready, 0);
    tick();
    check("t1_in_ready_post_edge", bif.in_ready, 1);

    // T2: all legal modes back-to-back
    bif.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bif.in_valid = 1'b1;
      bif.imm      = 16'h8004;
      bif.EOp      = 3'(i);
      tick();
      check("t2_out_valid", bif.out_valid, 1);
      check("t2_ext", bif.ext, t2_exp[i]);
      check("t2_in_ready", bif.in_ready, 1);
    end
    bif.in_valid = 1'b0;
    tick();
    check("t2_empty", bif.out_valid, 0);

    // T3: back-pressure fills the skid register
    bif.out_ready = 1'b0;
    bif.in_valid  = 1'b1;
    bif.imm       = 16'h0001;
    bif.EOp       = 3'b001;
    tick();
    check("t3_first", bif.ext, 32'h1);
    check("t3_rdy1", bif.in_ready, 1);
    bif.imm = 16'h0002;
    tick();
    bif.in_valid = 1'b0;
    check("t3_rdy_full", bif.in_ready, 0);
    check("t3_hold_a", bif.ext, 32'h1);
    tick();
    check("t3_hold_b", bif.ext, 32'h1);
    check("t3_hold_vld", bif.out_valid, 1);
    check("t3_hold_rdy", bif.in_ready, 0);
    bif.out_ready = 1'b1;
    tick();
    check("t3_second", bif.ext, 32'h2);
    check("t3_rdy_back", bif.in_ready, 1);
    tick();
    check("t3_drained", bif.out_valid, 0);

    // T4: illegal mode and sticky error
    bif.in_valid = 1'b1;
    bif.EOp      = 3'b110;
    bif.imm      = 16'h1234;
    tick();
    bif.in_valid = 1'b0;
    check("t4_ext", bif.ext, 0);
    check("t4_out_err", bif.out_err, 1);
    check("t4_sticky", err_sticky, 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("t4_cleared", err_sticky, 0);
    bif.in_valid = 1'b1;
    bif.EOp      = 3'b111;
    clr_err      = 1'b1;
    tick();
    bif.in_valid = 1'b0;
    clr_err      = 1'b0;
    check("t4_set_wins", err_sticky, 1);
    clr_err = 1'b1;
    tick();
    clr_err      = 1'b0;
    bif.in_valid = 1'b1;
    bif.EOp      = 3'b000;
    tick();
    bif.in_valid = 1'b0;
    check("t4_legal_no_set", err_sticky, 0);
    check("t4_legal_err", bif.out_err, 0);
    tick();

    // T5: reset with M and S both full
    bif.out_ready = 1'b0;
    bif.in_valid  = 1'b1;
    bif.EOp       = 3'b001;
    bif.imm       = 16'hAAAA;
    tick();
    bif.imm = 16'h5555;
    tick();
    bif.in_valid = 1'b0;
    check("t5_full", bif.in_ready, 0);
    check("t5_vld_before", bif.out_valid, 1);
    #2;
    reset = 1'b0;
    #1;
    sb.delete();
    check("t5_vld_async", bif.out_valid, 0);
    check("t5_ext_async", bif.ext, 0);
    check("t5_rdy_async", bif.in_ready, 0);
    check("t5_sticky_async", err_sticky, 0);
    tick();
    tick();
    reset = 1'b1;
    bif.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5_no_replay", bif.out_valid, 0);
    end

    // T6: random traffic against the scoreboard
    push_cnt = 0;
    pop_cnt  = 0;
    sent     = 0;
    for (int cyc = 0; cyc < 60000 && sent < 10000; cyc++) begin
      bif.in_valid  = ($urandom_range(0, 3) != 0);
      bif.imm       = 16'($urandom);
      bif.EOp       = 3'($urandom_range(0, 7));
      bif.out_ready = ($urandom_range(0, 3) != 0);
      if (bif.in_valid && bif.in_ready) sent++;
      tick();
    end
    bif.in_valid  = 1'b0;
    bif.out_ready = 1'b1;
    for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
    tick();
    check("t6_sent", sent, 10000);
    check("t6_pushed", push_cnt, 10000);
    check("t6_popped", pop_cnt, push_cnt);
    check("t6_sb_empty", sb.size(), 0);
    check("t6_out_idle", bif.out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
